// File: rtl/elbeth_memory_responder.sv
// Dual-port memory target for the core's instruction (A) and data (B) ports over one shared word array.
// Optional `ELBETH_MEM_IMEM_WRITE_PROTECT_EN makes port A read-only (writes complete with an error).
module elbeth_memory_responder #(
  parameter int ADDR_WIDTH = 14,
  parameter int MEM_WORDS  = 4096,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  a_en,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [3:0]            a_rw,
  input  logic [31:0]           a_wdata,
  output logic [31:0]           a_rdata,
  output logic                  a_ready,
  output logic                  a_error,
  input  logic                  b_en,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [3:0]            b_rw,
  input  logic [31:0]           b_wdata,
  output logic [31:0]           b_rdata,
  output logic                  b_ready,
  output logic                  b_error
);

  localparam int IW = ADDR_WIDTH - 2;
  localparam int MW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  logic [31:0] mem [MEM_WORDS];

  logic          en_in    [2];
  logic [IW-1:0] idx_in   [2];
  logic [3:0]    rw_in    [2];
  logic [31:0]   wdata_in [2];

  state_t        state_q [2];
  state_t        state_d [2];
  logic [3:0]    cnt_q   [2];
  logic [3:0]    cnt_d   [2];
  logic [IW-1:0] idx_q   [2];
  logic [3:0]    rw_q    [2];
  logic [31:0]   wdata_q [2];

  logic          go        [2];
  logic [IW-1:0] acc_idx   [2];
  logic [MW-1:0] mem_idx   [2];
  logic [3:0]    acc_rw    [2];
  logic [31:0]   acc_wdata [2];
  logic          acc_err   [2];
  logic          acc_wr    [2];

  logic [31:0]   rdata_q [2];
  logic          ready_q [2];
  logic          error_q [2];

  logic unused_addr_bits;
  assign unused_addr_bits = ^{a_addr[1:0], b_addr[1:0]};

  assign en_in[0]    = a_en;
  assign en_in[1]    = b_en;
  assign idx_in[0]   = a_addr[ADDR_WIDTH-1:2];
  assign idx_in[1]   = b_addr[ADDR_WIDTH-1:2];
  assign rw_in[0]    = a_rw;
  assign rw_in[1]    = b_rw;
  assign wdata_in[0] = a_wdata;
  assign wdata_in[1] = b_wdata;

  always_comb begin
    for (int unsigned p = 0; p < 2; p++) begin
      state_d[p] = state_q[p];
      cnt_d[p]   = cnt_q[p];
      go[p]      = 1'b0;
      case (state_q[p])
        IDLE: begin
          if (en_in[p]) begin
            cnt_d[p] = LAT_M1;
            if (LATENCY == 1) begin
              state_d[p] = RESP;
              go[p]      = 1'b1;
            end else begin
              state_d[p] = WAIT;
            end
          end
        end
        WAIT: begin
          cnt_d[p] = cnt_q[p] - 4'd1;
          if (cnt_q[p] == 4'd1) begin
            state_d[p] = RESP;
            go[p]      = 1'b1;
          end
        end
        RESP:    state_d[p] = IDLE;
        default: state_d[p] = IDLE;
      endcase

      // With LATENCY=1 the access edge is also the accept edge, so use the live request then.
      acc_idx[p]   = (state_q[p] == IDLE) ? idx_in[p]   : idx_q[p];
      acc_rw[p]    = (state_q[p] == IDLE) ? rw_in[p]    : rw_q[p];
      acc_wdata[p] = (state_q[p] == IDLE) ? wdata_in[p] : wdata_q[p];
      mem_idx[p]   = acc_idx[p][MW-1:0];
      acc_err[p]   = 32'(acc_idx[p]) >= 32'(MEM_WORDS);
`ifdef ELBETH_MEM_IMEM_WRITE_PROTECT_EN
      if (p == 0 && acc_rw[p] != 4'b0000) acc_err[p] = 1'b1;
`endif
      acc_wr[p] = go[p] && !acc_err[p] && (acc_rw[p] != 4'b0000);
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned p = 0; p < 2; p++) begin
      if (rst) begin
        state_q[p] <= IDLE;
        cnt_q[p]   <= '0;
        ready_q[p] <= 1'b0;
        error_q[p] <= 1'b0;
        rdata_q[p] <= '0;
      end else begin
        state_q[p] <= state_d[p];
        cnt_q[p]   <= cnt_d[p];
        if (state_q[p] == IDLE && en_in[p]) begin
          idx_q[p]   <= idx_in[p];
          rw_q[p]    <= rw_in[p];
          wdata_q[p] <= wdata_in[p];
        end
        ready_q[p] <= go[p];
        error_q[p] <= go[p] && acc_err[p];
        rdata_q[p] <= (go[p] && !acc_err[p] && acc_rw[p] == 4'b0000) ? mem[mem_idx[p]] : '0;
      end
    end
  end

  // Port B is written after port A so it owns overlapping lanes on a same-edge collision.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned p = 0; p < 2; p++) begin
        if (acc_wr[p]) begin
          for (int unsigned l = 0; l < 4; l++) begin
            if (acc_rw[p][l]) mem[mem_idx[p]][8*l +: 8] <= acc_wdata[p][8*l +: 8];
          end
        end
      end
    end
  end

  assign a_rdata = rdata_q[0];
  assign a_ready = ready_q[0];
  assign a_error = error_q[0];
  assign b_rdata = rdata_q[1];
  assign b_ready = ready_q[1];
  assign b_error = error_q[1];

endmodule
